// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the oversampling UART receiver slice:
//   - rx_state_t      : receiver FSM state encodings
//   - OVERSAMPLE_DEF  : default UART_CE ticks per bit
//   - DATA_BITS_DEF   : default payload bits per frame
//   - PAR_EVEN/PAR_ODD: parity sense selectors
//   - maj3()          : three-input majority vote used by the bit sampler
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Majority of three samples: any two agreeing ones decide a 1.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Synchronises the asynchronous RXD line and produces the majority-voted bit
// value from three samples centred in the bit period.
// Ports:
//   CLK       in   system clock (rising edge)
//   RST       in   asynchronous active-high reset
//   UART_CE   in   oversampling clock-enable tick
//   RXD       in   raw serial line
//   i_cnt     in   tick position inside the current bit (0..OVERSAMPLE-1)
//   o_rxs     out  synchronised line value
//   o_bit_val out  majority of the samples at centre-1, centre and centre+1;
//                  only meaningful on the CE tick where i_cnt = centre+1
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int CNT_WDT    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               UART_CE,
    input  logic               RXD,
    input  logic [CNT_WDT-1:0] i_cnt,
    output logic               o_rxs,
    output logic               o_bit_val
);

    localparam logic [CNT_WDT-1:0] C_SAMP_A = CNT_WDT'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_WDT-1:0] C_SAMP_B = CNT_WDT'(OVERSAMPLE / 2);

    logic r_sync1;
    logic r_sync2;
    logic r_samp_a;
    logic r_samp_b;

    // Two-flop synchroniser (idle-high reset) and capture of the first two votes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            if (UART_CE) begin
                if (i_cnt == C_SAMP_A) begin
                    r_samp_a <= r_sync2;
                end
                if (i_cnt == C_SAMP_B) begin
                    r_samp_b <= r_sync2;
                end
            end
        end
    end

    // The third sample is the live synchronised value on the deciding tick.
    assign o_rxs     = r_sync2;
    assign o_bit_val = maj3(r_samp_a, r_samp_b, r_sync2);

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver. Detects and validates the start bit, collects
// DATA_BITS payload bits LSB first, optionally checks one parity bit, and
// checks a single stop bit. Each frame is presented with a one-cycle VALID.
// Ports:
//   CLK        in   system clock (rising edge)
//   RST        in   asynchronous active-high reset
//   UART_CE    in   tick at OVERSAMPLE x baud
//   RXD        in   asynchronous serial line, idles high
//   DATA       out  last received payload, held until the next VALID
//   VALID      out  one-CLK pulse per completed frame
//   FRAME_ERR  out  stop-bit vote of the last frame was 0
//   PARITY_ERR out  parity check of the last frame failed
//   BUSY       out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int CNT_WDT    = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UART_CE,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 BUSY
);

    localparam int IDX_W = 4;

    localparam logic [CNT_WDT-1:0] C_VOTE     = CNT_WDT'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_WDT-1:0] C_LAST     = CNT_WDT'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]   C_LAST_BIT = IDX_W'(DATA_BITS - 1);
    localparam logic               C_PAR_ODD  = (PARITY_ODD != 0);
    localparam logic               C_PAR_EN   = (PARITY_EN != 0);

    rx_state_t            r_state;
    logic [CNT_WDT-1:0]   r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_busy;

    logic w_rxs;
    logic w_bit_val;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_WDT    (CNT_WDT)
    ) u_sampler (
        .CLK       (CLK),
        .RST       (RST),
        .UART_CE   (UART_CE),
        .RXD       (RXD),
        .i_cnt     (r_cnt),
        .o_rxs     (w_rxs),
        .o_bit_val (w_bit_val)
    );

    // Receiver FSM, tick counter, shift register and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // VALID is a single-CLK strobe, independent of CE.
            r_valid <= 1'b0;
            if (UART_CE) begin
                case (r_state)
                    ST_IDLE: begin
                        // The detecting tick is tick 0 of the start bit.
                        if (!w_rxs) begin
                            r_state <= ST_START;
                            r_cnt   <= CNT_WDT'(1);
                            r_busy  <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if ((r_cnt == C_VOTE) && w_bit_val) begin
                            // Glitch, not a start bit: drop back silently.
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == C_LAST) begin
                            r_state <= ST_DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_WDT'(1);
                        end
                    end

                    ST_DATA: begin
                        if (r_cnt == C_VOTE) begin
                            // LSB arrives first and walks down to bit 0.
                            r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_cnt == C_LAST) begin
                            r_cnt <= '0;
                            if (r_idx == C_LAST_BIT) begin
                                r_state <= C_PAR_EN ? ST_PARITY : ST_STOP;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_WDT'(1);
                        end
                    end

                    ST_PARITY: begin
                        if (r_cnt == C_VOTE) begin
                            r_par_err <= w_bit_val ^ (^r_shift) ^ C_PAR_ODD;
                        end
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_STOP;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_WDT'(1);
                        end
                    end

                    ST_STOP: begin
                        if (r_cnt == C_VOTE) begin
                            // Deliver at the vote; the rest of the stop bit is
                            // not waited out so back-to-back frames are caught.
                            r_data       <= r_shift;
                            r_frame_err  <= ~w_bit_val;
                            r_parity_err <= C_PAR_EN & r_par_err;
                            r_valid      <= 1'b1;
                            r_cnt        <= '0;
                            if (w_bit_val) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_BREAK_WAIT;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_WDT'(1);
                        end
                    end

                    ST_BREAK_WAIT: begin
                        // A held-low line must return high before re-arming.
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA       = r_data;
    assign VALID      = r_valid;
    assign FRAME_ERR  = r_frame_err;
    assign PARITY_ERR = r_parity_err;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Self-checking bench: dut0 is 8N1, dut1 is 8E1. Frames are driven bit by bit
// (64 CLK per bit: CE every 4 CLK, 16 ticks per bit); an expected-frame queue
// per DUT is filled from the frame contents and checked on every VALID.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       busy;
    } exp_t;

    localparam int   BIT_CLK = 64;
    localparam logic PODD    = 1'b0;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       uart_ce = 1'b0;
    logic [1:0] ce_div  = 2'd0;
    logic [1:0] rxd     = 2'b11;
    int         cyc     = 0;

    logic [7:0] data0, data1;
    logic       valid0, valid1, fe0, fe1, pe0, pe1, busy0, busy1;

    int n_cmp = 0;
    int n_err = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] last_d0 = 8'h00;
    logic [7:0] last_d1 = 8'h00;
    int         t_prev0 = 0;
    int         t_last0 = 0;

    uart_rx_os dut0 (
        .CLK(clk), .RST(rst), .UART_CE(uart_ce), .RXD(rxd[0]),
        .DATA(data0), .VALID(valid0), .FRAME_ERR(fe0), .PARITY_ERR(pe0), .BUSY(busy0)
    );

    uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .CLK(clk), .RST(rst), .UART_CE(uart_ce), .RXD(rxd[1]),
        .DATA(data1), .VALID(valid1), .FRAME_ERR(fe1), .PARITY_ERR(pe1), .BUSY(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ce_div  <= ce_div + 2'd1;
        uart_ce <= (ce_div == 2'd3);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic score(input int which, input logic [7:0] d, input logic fe,
                         input logic pe, input logic busy);
        exp_t e;
        if (which == 0) begin
            if (q0.size() == 0) begin
                check_eq("unexpected_valid0", 32'd1, 32'd0);
                return;
            end
            e = q0.pop_front();
            last_d0 = e.d;
        end else begin
            if (q1.size() == 0) begin
                check_eq("unexpected_valid1", 32'd1, 32'd0);
                return;
            end
            e = q1.pop_front();
            last_d1 = e.d;
        end
        check_eq($sformatf("data%0d", which), {24'd0, d}, {24'd0, e.d});
        check_eq($sformatf("frame_err%0d", which), {31'd0, fe}, {31'd0, e.fe});
        check_eq($sformatf("parity_err%0d", which), {31'd0, pe}, {31'd0, e.pe});
        check_eq($sformatf("busy_at_valid%0d", which), {31'd0, busy}, {31'd0, e.busy});
    endtask

    always @(negedge clk) begin
        if (!rst && valid0) begin
            t_prev0 <= t_last0;
            t_last0 <= cyc;
            score(0, data0, fe0, pe0, busy0);
        end
        if (!rst && valid1) begin
            score(1, data1, fe1, pe1, busy1);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optionally invert the single centre sample of the bit.
    task automatic drive_bit(input int which, input logic v, input logic glitch);
        rxd[which] = v;
        if (glitch) begin
            wait_clk(32);
            rxd[which] = ~v;
            wait_clk(4);
            rxd[which] = v;
            wait_clk(28);
        end else begin
            wait_clk(BIT_CLK);
        end
    endtask

    // Queue the expected result, then drive start, data, [parity], stop.
    task automatic send_frame(input int which, input logic [7:0] d, input logic par_bit,
                              input logic stop_bit, input int glitch);
        exp_t e;
        int   k;
        e.d    = d;
        e.fe   = ~stop_bit;
        e.pe   = (which == 1) ? (par_bit ^ (^d) ^ PODD) : 1'b0;
        e.busy = ~stop_bit;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
        k = 0;
        drive_bit(which, 1'b0, glitch == k);
        k++;
        for (int i = 0; i < 8; i++) begin
            drive_bit(which, d[i], glitch == k);
            k++;
        end
        if (which == 1) begin
            drive_bit(which, par_bit, glitch == k);
            k++;
        end
        drive_bit(which, stop_bit, glitch == k);
        rxd[which] = 1'b1;
    endtask

    task automatic check_reset(input int which);
        if (which == 0) begin
            check_eq("rst_data0", {24'd0, data0}, 32'd0);
            check_eq("rst_valid0", {31'd0, valid0}, 32'd0);
            check_eq("rst_fe0", {31'd0, fe0}, 32'd0);
            check_eq("rst_pe0", {31'd0, pe0}, 32'd0);
            check_eq("rst_busy0", {31'd0, busy0}, 32'd0);
        end else begin
            check_eq("rst_data1", {24'd0, data1}, 32'd0);
            check_eq("rst_valid1", {31'd0, valid1}, 32'd0);
            check_eq("rst_fe1", {31'd0, fe1}, 32'd0);
            check_eq("rst_pe1", {31'd0, pe1}, 32'd0);
            check_eq("rst_busy1", {31'd0, busy1}, 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       rstop;
        logic       rpar;
        int         rg;
        int         gap;

        // Reset values
        rst = 1'b1;
        rxd = 2'b11;
        wait_clk(5);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        wait_clk(8);

        // Plain 8N1 frame
        send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
        wait_clk(8);
        check_eq("a5_drain", q0.size(), 32'd0);

        // False start: line low for three CE ticks only
        rxd[0] = 1'b0;
        wait_clk(12);
        rxd[0] = 1'b1;
        wait_clk(2);
        check_eq("false_start_busy_hi", {31'd0, busy0}, 32'd1);
        wait_clk(60);
        check_eq("false_start_busy_lo", {31'd0, busy0}, 32'd0);
        check_eq("false_start_data", {24'd0, data0}, {24'd0, last_d0});
        check_eq("false_start_fe", {31'd0, fe0}, 32'd0);
        wait_clk(BIT_CLK);

        // Break: line low for 20 bit times gives one VALID with frame error
        begin
            exp_t e;
            e.d = 8'h00; e.fe = 1'b1; e.pe = 1'b0; e.busy = 1'b1;
            q0.push_back(e);
        end
        rxd[0] = 1'b0;
        wait_clk(20 * BIT_CLK);
        check_eq("break_one_valid", q0.size(), 32'd0);
        check_eq("break_busy", {31'd0, busy0}, 32'd1);
        rxd[0] = 1'b1;
        wait_clk(BIT_CLK);
        check_eq("break_released", {31'd0, busy0}, 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1);
        wait_clk(8);
        check_eq("after_break_drain", q0.size(), 32'd0);

        // Even parity: 0x07 has three ones
        send_frame(1, 8'h07, 1'b0, 1'b1, -1);
        send_frame(1, 8'h07, 1'b1, 1'b1, -1);
        wait_clk(8);
        check_eq("parity_drain", q1.size(), 32'd0);

        // Back-to-back frames, centre sample of data bit 3 inverted in the second
        send_frame(0, 8'h55, 1'b0, 1'b1, -1);
        send_frame(0, 8'hAA, 1'b0, 1'b1, 4);
        wait_clk(8);
        check_eq("b2b_drain", q0.size(), 32'd0);
        check_eq("b2b_gap_clk", t_last0 - t_prev0, 32'd640);

        // Reset in the middle of data bit 4
        rxd[0] = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rxd[0] = i[0];
            wait_clk(BIT_CLK);
        end
        rxd[0] = 1'b0;
        wait_clk(32);
        rst = 1'b1;
        wait_clk(2);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        rxd[0] = 1'b1;
        last_d0 = 8'h00;
        last_d1 = 8'h00;
        wait_clk(2 * BIT_CLK);
        check_eq("post_rst_busy", {31'd0, busy0}, 32'd0);
        check_eq("post_rst_data", {24'd0, data0}, 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b1, -1);
        wait_clk(8);
        check_eq("post_rst_drain", q0.size(), 32'd0);

        // Randomised 8N1 traffic with occasional frame errors and glitches
        for (int n = 0; n < 16; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 4) != 0);
            rg    = $urandom_range(0, 10);
            if (rg == 10) rg = -1;
            send_frame(0, rd, 1'b0, rstop, rg);
            gap = rstop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            wait_clk(gap * BIT_CLK);
        end
        wait_clk(8);
        check_eq("rand0_drain", q0.size(), 32'd0);

        // Randomised 8E1 traffic with random parity bits
        for (int n = 0; n < 8; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rpar  = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 4) != 0);
            rg    = $urandom_range(0, 11);
            if (rg == 11) rg = -1;
            send_frame(1, rd, rpar, rstop, rg);
            gap = rstop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            wait_clk(gap * BIT_CLK);
        end
        wait_clk(8);
        check_eq("rand1_drain", q1.size(), 32'd0);

        wait_clk(200);
        check_eq("final_q0", q0.size(), 32'd0);
        check_eq("final_q1", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
